// File: rtl/bram_responder_pkg.sv
// Shared types for the bram responder: FSM state encoding and debug counter width.
// Combinational helpers only; no storage here.
package bram_responder_pkg;

    localparam int C_ACCESS_COUNT_WIDTH = 16;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_ACCESS = 2'b01,
        S_RESP   = 2'b10
    } state_t;

    localparam logic [C_ACCESS_COUNT_WIDTH-1:0] C_COUNT_ONE = 1;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [C_ACCESS_COUNT_WIDTH-1:0] sat_inc(
        input logic [C_ACCESS_COUNT_WIDTH-1:0] value
    );
        return (&value) ? value : value + C_COUNT_ONE;
    endfunction

endpackage

// File: rtl/bram.sv
// Dual-port block RAM, synchronous read (read-first), one clock for both ports.
// Latency 1 cycle on each port; no flow control. Contents are not reset.
module bram #(
    parameter string P_INIT_FILE     = "",
    parameter int    P_DATA_WIDTH    = 16,
    parameter int    P_ADDRESS_WIDTH = 10
) (
    input  logic                       I_CLK,
    input  logic                       I_WE_A,
    input  logic [P_ADDRESS_WIDTH-1:0] I_ADDRESS_A,
    input  logic [P_DATA_WIDTH-1:0]    I_DATA_A,
    output logic [P_DATA_WIDTH-1:0]    O_DATA_A,
    input  logic                       I_WE_B,
    input  logic [P_ADDRESS_WIDTH-1:0] I_ADDRESS_B,
    input  logic [P_DATA_WIDTH-1:0]    I_DATA_B,
    output logic [P_DATA_WIDTH-1:0]    O_DATA_B
);

    localparam int C_DEPTH = 1 << P_ADDRESS_WIDTH;

    // Preloading is done by the vendor memory flow; this model powers up undefined.
    localparam bit C_INIT_REQUESTED_UNUSED = (P_INIT_FILE != "");

    logic [P_DATA_WIDTH-1:0] mem_q [C_DEPTH];

    always_ff @(posedge I_CLK) begin
        O_DATA_A <= mem_q[I_ADDRESS_A];
        O_DATA_B <= mem_q[I_ADDRESS_B];
        if (I_WE_A) begin
            mem_q[I_ADDRESS_A] <= I_DATA_A;
        end
        if (I_WE_B) begin
            mem_q[I_ADDRESS_B] <= I_DATA_B;
        end
    end

endmodule

// File: rtl/bram_responder.sv
// Valid/ready front end for bram port A, one request in flight, one response per request.
// Response valid 2 edges after acceptance; response held indefinitely while I_RSP_READY=0.
module bram_responder
    import bram_responder_pkg::*;
#(
    parameter string P_BRAM_INIT_FILE = "",
    parameter int    P_DATA_WIDTH     = 16,
    parameter int    P_ADDRESS_WIDTH  = 10
) (
    input  logic                            I_CLK,
    input  logic                            I_NRESET,
    input  logic                            I_REQ_VALID,
    output logic                            O_REQ_READY,
    input  logic                            I_REQ_WRITE,
    input  logic [P_ADDRESS_WIDTH-1:0]      I_REQ_ADDRESS,
    input  logic [P_DATA_WIDTH-1:0]         I_REQ_DATA,
    output logic                            O_RSP_VALID,
    input  logic                            I_RSP_READY,
    output logic [P_DATA_WIDTH-1:0]         O_RSP_DATA,
    output logic                            O_RSP_WRITE,
    output logic [C_ACCESS_COUNT_WIDTH-1:0] O_ACCESS_COUNT
);

    state_t                            state_q;
    logic [P_ADDRESS_WIDTH-1:0]        address_q;
    logic [P_DATA_WIDTH-1:0]           data_q;
    logic                              write_q;
    logic                              we_q;
    logic [C_ACCESS_COUNT_WIDTH-1:0]   count_q;
    logic [C_ACCESS_COUNT_WIDTH-1:0]   count_d;
    logic [P_DATA_WIDTH-1:0]           bram_dout_a;
    logic [P_DATA_WIDTH-1:0]           bram_dout_b_unused;

    assign count_d = sat_inc(count_q);

    // The async clear of we_q is what cancels a write whose commit edge has not happened yet.
    always_ff @(posedge I_CLK or negedge I_NRESET) begin
        if (!I_NRESET) begin
            state_q   <= S_IDLE;
            address_q <= '0;
            data_q    <= '0;
            write_q   <= 1'b0;
            we_q      <= 1'b0;
            count_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (I_REQ_VALID) begin
                        address_q <= I_REQ_ADDRESS;
                        data_q    <= I_REQ_DATA;
                        write_q   <= I_REQ_WRITE;
                        we_q      <= I_REQ_WRITE;
                        state_q   <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    we_q    <= 1'b0;
                    state_q <= S_RESP;
                end
                S_RESP: begin
                    if (I_RSP_READY) begin
                        count_q <= count_d;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    we_q    <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign O_REQ_READY    = (state_q == S_IDLE);
    assign O_RSP_VALID    = (state_q == S_RESP);
    assign O_RSP_WRITE    = write_q;
    assign O_ACCESS_COUNT = count_q;

    // Writes echo their own data so the result never depends on the RAM's read-during-write mode.
    assign O_RSP_DATA = (state_q != S_RESP) ? '0 :
                        write_q             ? data_q : bram_dout_a;

    bram #(
        .P_INIT_FILE     (P_BRAM_INIT_FILE),
        .P_DATA_WIDTH    (P_DATA_WIDTH),
        .P_ADDRESS_WIDTH (P_ADDRESS_WIDTH)
    ) u_bram (
        .I_CLK       (I_CLK),
        .I_WE_A      (we_q),
        .I_ADDRESS_A (address_q),
        .I_DATA_A    (data_q),
        .O_DATA_A    (bram_dout_a),
        .I_WE_B      (1'b0),
        .I_ADDRESS_B ('0),
        .I_DATA_B    ('0),
        .O_DATA_B    (bram_dout_b_unused)
    );

endmodule

// File: tb/tb_bram_responder.sv
// Bench for bram_responder: table vectors, reset corner cases, random traffic, counter saturation.
module tb_bram_responder;

    logic        clk = 1'b0;
    logic        nreset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [9:0]  req_addr;
    logic [15:0] req_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic        rsp_write;
    logic [15:0] access_count;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem_model [1024];
    bit          known     [1024];
    int unsigned count_model;

    always #5 clk = ~clk;

    bram_responder #(
        .P_BRAM_INIT_FILE (""),
        .P_DATA_WIDTH     (16),
        .P_ADDRESS_WIDTH  (10)
    ) dut (
        .I_CLK          (clk),
        .I_NRESET       (nreset),
        .I_REQ_VALID    (req_valid),
        .O_REQ_READY    (req_ready),
        .I_REQ_WRITE    (req_write),
        .I_REQ_ADDRESS  (req_addr),
        .I_REQ_DATA     (req_data),
        .O_RSP_VALID    (rsp_valid),
        .I_RSP_READY    (rsp_ready),
        .O_RSP_DATA     (rsp_data),
        .O_RSP_WRITE    (rsp_write),
        .O_ACCESS_COUNT (access_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, req_ready, 1);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_rsp_write"}, rsp_write, 0);
        check({tag, "_rsp_data"}, rsp_data, 0);
        check({tag, "_count"}, access_count, 0);
    endtask

    // One full transaction; stall>0 holds I_RSP_READY low that many cycles while a
    // competing write request is waved at the busy DUT.
    task automatic txn(input bit wr, input logic [9:0] a, input logic [15:0] d,
                       input int stall, input logic [15:0] exp_data);
        int n;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_data  = d;
        rsp_ready = (stall == 0);
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL req_ready_timeout: ready stayed %b after %0d cycles", req_ready, n);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("access_rsp_valid", rsp_valid, 0);
        check("access_req_ready", req_ready, 0);
        @(negedge clk);
        check("rsp_valid", rsp_valid, 1);
        check("rsp_data", rsp_data, exp_data);
        check("rsp_write", rsp_write, wr);
        for (int i = 0; i < stall; i++) begin
            req_valid = 1'b1;
            req_write = 1'b1;
            req_addr  = 10'd1;
            req_data  = 16'hBEEF;
            @(negedge clk);
            check("stall_rsp_valid", rsp_valid, 1);
            check("stall_rsp_data", rsp_data, exp_data);
            check("stall_req_ready", req_ready, 0);
            check("stall_count", access_count, count_model);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        if (wr) begin
            mem_model[a] = d;
            known[a]     = 1'b1;
        end
        if (count_model < 32'hFFFF) count_model++;
        check("done_req_ready", req_ready, 1);
        check("done_rsp_valid", rsp_valid, 0);
        check("done_count", access_count, count_model);
    endtask

    typedef struct {
        bit          wr;
        logic [9:0]  addr;
        logic [15:0] data;
        int          stall;
        logic [15:0] exp_data;
        logic [15:0] exp_count;
    } vec_t;

    vec_t vecs [5];

    initial begin
        bit          wr;
        logic [9:0]  a;
        logic [15:0] d;

        vecs[0] = '{1'b0, 10'd0,    16'h0000, 0, 16'h0303, 16'd1};
        vecs[1] = '{1'b1, 10'd1023, 16'h00AA, 0, 16'h00AA, 16'd2};
        vecs[2] = '{1'b0, 10'd1023, 16'h0000, 0, 16'h00AA, 16'd3};
        vecs[3] = '{1'b0, 10'd1,    16'h0000, 5, 16'h0002, 16'd4};
        vecs[4] = '{1'b0, 10'd1,    16'h0000, 0, 16'h0002, 16'd5};

        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_data  = '0;
        rsp_ready = 1'b0;
        count_model = 0;
        nreset = 1'b0;
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        nreset = 1'b1;

        // Preload the test image, then reset: memory must survive, count must clear.
        txn(1'b1, 10'd0,    16'h0303, 0, 16'h0303);
        txn(1'b1, 10'd1,    16'h0002, 0, 16'h0002);
        txn(1'b1, 10'd1023, 16'h0023, 0, 16'h0023);
        @(negedge clk);
        nreset = 1'b0;
        count_model = 0;
        @(negedge clk);
        nreset = 1'b1;
        check_reset_outputs("reset2");

        for (int i = 0; i < 5; i++) begin
            txn(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].stall, vecs[i].exp_data);
            check("vec_count", access_count, vecs[i].exp_count);
        end

        // Reset in S_ACCESS: write to addr 0 must not commit.
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 10'd0;
        req_data  = 16'h0001;
        rsp_ready = 1'b1;
        check("abort_idle_ready", req_ready, 1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("abort_in_access", req_ready, 0);
        #1 nreset = 1'b0;
        #1 check_reset_outputs("abort_write");
        count_model = 0;
        @(negedge clk);
        nreset = 1'b1;
        rsp_ready = 1'b0;
        txn(1'b0, 10'd0, 16'h0000, 0, 16'h0303);

        // Reset in S_RESP drops the response and clears the count.
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 10'd1;
        rsp_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("drop_rsp_valid", rsp_valid, 1);
        check("drop_count_before", access_count, 1);
        #1 nreset = 1'b0;
        #1 check_reset_outputs("drop_rsp");
        count_model = 0;
        @(negedge clk);
        nreset = 1'b1;

        // Random traffic against the array model; reads only hit known addresses.
        for (int i = 0; i < 40; i++) begin
            wr = $urandom_range(0, 1);
            a  = ($urandom_range(0, 1) == 1) ? 10'($urandom_range(0, 7))
                                             : 10'(1023 - $urandom_range(0, 7));
            d  = 16'($urandom);
            if (!known[a]) wr = 1'b1;
            txn(wr, a, d, $urandom_range(0, 2), wr ? d : mem_model[a]);
        end

        // Saturation: jump the counter to FFFE, then three more transactions.
        @(negedge clk);
        force dut.count_q = 16'hFFFE;
        #1 release dut.count_q;
        count_model = 32'hFFFE;
        txn(1'b0, 10'd0, 16'h0000, 0, mem_model[0]);
        check("sat_first", access_count, 16'hFFFF);
        txn(1'b0, 10'd1023, 16'h0000, 0, mem_model[1023]);
        check("sat_hold1", access_count, 16'hFFFF);
        txn(1'b1, 10'd2, 16'h5A5A, 1, 16'h5A5A);
        check("sat_hold2", access_count, 16'hFFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bram_responder.md
Name: bram_responder

Overview:
- Handshaked memory responder that fronts one port of the team's dual-port `bram` and serves single read/write requests from an initiator (CPU load/store unit, test FSMs).
- The request channel and the response channel are both valid/ready.
- One request is in flight at a time. Every request produces exactly one response, including writes (acknowledged).
- A saturating counter of completed transactions is exposed for debug and 7-segment display.

Parameters:
P_BRAM_INIT_FILE, "", memory init file passed through to `bram` ("" = no init)
P_DATA_WIDTH, 16, data word width
P_ADDRESS_WIDTH, 10, word address width (depth = 2**P_ADDRESS_WIDTH)

Ports:
I_CLK  in  1  clock; all state updates on posedge
I_NRESET  in  1  reset, asynchronous, active-low
I_REQ_VALID  in  1  request valid
O_REQ_READY  out  1  request ready; 1 only in S_IDLE
I_REQ_WRITE  in  1  1 = write, 0 = read
I_REQ_ADDRESS  in  P_ADDRESS_WIDTH  word address
I_REQ_DATA  in  P_DATA_WIDTH  write data (ignored for reads)
O_RSP_VALID  out  1  response valid; 1 only in S_RESP
I_RSP_READY  in  1  response accepted by initiator
O_RSP_DATA  out  P_DATA_WIDTH  read data, or the written data echoed for writes
O_RSP_WRITE  out  1  echo of I_REQ_WRITE for the response
O_ACCESS_COUNT  out  16  completed response handshakes, saturating at 16'hFFFF

Behaviour:
- States: S_IDLE, S_ACCESS, S_RESP. Encoding is 2 bits; the unused code returns to S_IDLE on the next edge.
- Reset (asynchronous, I_NRESET=0):
  - state = S_IDLE; O_REQ_READY = 1; O_RSP_VALID = 0; O_RSP_WRITE = 0; O_RSP_DATA = 0; O_ACCESS_COUNT = 0.
  - Internal address/data/write-enable registers = 0.
  - Memory contents are not cleared.
- S_IDLE: on an edge with I_REQ_VALID & O_REQ_READY:
  - latch address, data and write into request registers;
  - assert the registered bram write-enable if the request is a write;
  - go to S_ACCESS.
  - Otherwise stay in S_IDLE.
- S_ACCESS (exactly 1 cycle):
  - bram port A is driven from the request registers and samples them at the edge leaving S_ACCESS, which is the write commit point.
  - Write-enable is cleared at that same edge.
  - Go to S_RESP.
- S_RESP:
  - O_RSP_VALID = 1. Port A address is held and write-enable is 0, so the bram output stays stable.
  - Read: O_RSP_DATA = bram O_DATA_A.
  - Write: O_RSP_DATA = latched write data. This is independent of bram read-during-write mode.
  - Response fields stay stable while I_RSP_READY = 0, for unbounded back-pressure.
  - On an edge with I_RSP_READY = 1: go to S_IDLE and increment O_ACCESS_COUNT unless it is 16'hFFFF.
- Latency and throughput:
  - Request accepted at edge E0; O_RSP_VALID high after E1.
  - With I_RSP_READY held at 1: minimum 3 cycles per transaction, O_REQ_READY high again after E2.
- Port B of `bram` is unused: write-enable 0, address 0, data 0.
- Addresses are full width, so there is no out-of-range case. Address 2**P_ADDRESS_WIDTH-1 is valid; no wrap-around logic.
- I_REQ_VALID during S_ACCESS or S_RESP is ignored (not accepted, no side effect). The initiator holds the request until it sees ready.
- Reset mid-operation:
  - Reset asserted before the S_ACCESS commit edge means the write does not happen, because write-enable is cleared asynchronously.
  - Reset in S_RESP drops the response without incrementing the count.
- Simultaneous I_RSP_READY and I_REQ_VALID in S_RESP: only the response completes; the new request is accepted from S_IDLE at the next edge.

Decomposition:
- Shared package holds:
  - the state typedef (S_IDLE, S_ACCESS, S_RESP);
  - the constant C_ACCESS_COUNT_WIDTH = 16.
- Sub-module: the existing `bram`, one instance, port A only. No other sub-module is needed.

Test Plan:
- Test init file: addr 0 = 16'h0303, addr 1 = 16'h0002, addr 1023 = 16'h0023.
- Reset, then read addr 0 with I_RSP_READY=1 -> O_RSP_VALID high 2 edges after acceptance, O_RSP_DATA = 16'h0303, O_RSP_WRITE = 0, O_ACCESS_COUNT = 1.
- Write 16'h00AA to addr 1023, then read addr 1023 -> write response O_RSP_DATA = 16'h00AA with O_RSP_WRITE = 1; read returns 16'h00AA; count = 2.
- Read addr 1 with I_RSP_READY=0 for 5 cycles -> O_RSP_VALID and O_RSP_DATA = 16'h0002 stable all 5 cycles, O_REQ_READY = 0, a new I_REQ_VALID is ignored; count increments only once, after ready rises.
- Write 16'h0001 to addr 0 and assert I_NRESET=0 during S_ACCESS before the commit edge -> outputs at reset values immediately; a later read of addr 0 returns 16'h0303.
- Force the counter to 16'hFFFE (back-to-back reads, or a bench force), then complete 3 transactions -> O_ACCESS_COUNT = 16'hFFFF and holds.
